preempt_timer: RTL and testbench
================================

Name: preempt_timer

Overview:
- Preemption quantum timer that drives the `timeout` input of the control unit.
- The control unit loads a quantum from the bus with its `timer_in` strobe. The block counts the quantum down only while the CPU is unprivileged, then raises a sticky `timeout`.
- The control unit samples `timeout` at instruction end and enters its trap sequence (T1).

Parameters:
- WIDTH, 16, width of the bus and quantum counter.
- PRESCALE, 4, clocks per counter decrement; legal range 1..256.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- timer_in  input  1  load strobe from control unit; samples bus_in on the same edge.
- bus_in  input  WIDTH  internal data bus; carries the quantum value.
- privileged  input  1  PSW bit 2; 1 = kernel mode, counting paused.
- timeout  output  1  registered, sticky quantum-expired flag.
- count_out  output  WIDTH  current counter value, registered, for debug/PSW readback.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0, prescaler=0, quantum register=0.
  - timeout=0, count_out=0.
  - Release is sampled synchronously.
- State IDLE (no quantum armed):
  - counter holds, timeout=0.
  - timer_in=1 with bus_in!=0 → RUN: counter=bus_in, quantum=bus_in, prescaler=0.
  - timer_in=1 with bus_in=0 → stays IDLE, quantum=0.
- State RUN:
  - privileged=1: prescaler and counter hold (pause, no reset of progress).
  - privileged=0: prescaler increments each clock.
  - When prescaler==PRESCALE-1: prescaler wraps to 0 and counter decrements by 1.
  - Decrement from 1 to 0 → EXPIRED; timeout=1 on that same edge.
  - Latency: load N, privileged held 0 → timeout rises exactly N*PRESCALE clocks after the load edge.
- State EXPIRED:
  - timeout=1, counter=0; privileged ignored.
  - Only timer_in clears timeout, then follows the IDLE load rules (bus_in!=0 → RUN, bus_in=0 → IDLE).
- timer_in priority:
  - Legal in every state.
  - Load always wins over a same-cycle decrement or expiry.
  - A load on the expiry cycle leaves timeout=0 and the counter at the new value.
- Arithmetic:
  - Counter is unsigned WIDTH bits and never wraps below 0.
  - Prescaler is ceil(log2(PRESCALE)) bits, minimum 1.
  - PRESCALE=1 → decrement every unprivileged clock.
- count_out always equals the counter register.
- Reset mid-count returns to IDLE immediately (asynchronous); the quantum is lost.

Optional Feature:
- Macro: TIMER_AUTO_RELOAD_EN.
- Defined:
  - On expiry, the counter reloads from the quantum register on the same edge, prescaler=0, state remains RUN.
  - timeout is set and stays 1 (sticky) until the next timer_in.
  - Counting continues, so repeated expiries are possible.
- Undefined: behaviour as above; counter stops at 0 in EXPIRED; the quantum register may be optimized away.

Test Plan:
- Reset, then load: hold reset=0 3 cycles → timeout=0, count_out=0. Release, timer_in=1, bus_in=3, privileged=0, PRESCALE=4 → count_out 3,2,1,0 at +4/+8/+12 clocks; timeout=1 at +12, stays 1 for ≥20 cycles.
- Privileged pause: load 2, run 5 clocks, privileged=1 for 10 clocks → count_out frozen at 1. Deassert → timeout rises 3 clocks later (8 unprivileged clocks total).
- Zero load: timer_in=1, bus_in=0 → state IDLE, timeout=0 indefinitely.
- Load vs expiry collision: load 1 and let it count; assert timer_in with bus_in=5 on the clock where expiry would occur → timeout stays 0, count_out=5.
- Clear from EXPIRED: after expiry, timer_in with bus_in=2 → timeout=0 next cycle, count_out=2. Mid-count reset=0 → timeout=0 and count_out=0 asynchronously.
- TIMER_AUTO_RELOAD_EN, PRESCALE=1: load 2 → timeout=1 at +2, count_out sequence 2,1,2,1,2; timeout stays 1 until timer_in.

Source files
------------

// File: rtl/preempt_timer_if.sv
// Signal bundle between the control unit and the preemption quantum timer.
// The control unit (master) loads quanta and supplies the privilege bit.
// The timer (slave) returns the sticky timeout and the live counter value.
interface preempt_timer_if #(
    parameter int WIDTH = 16
);
    logic             timer_in;
    logic [WIDTH-1:0] bus_in;
    logic             privileged;
    logic             timeout;
    logic [WIDTH-1:0] count_out;

    modport master (
        output timer_in, bus_in, privileged,
        input  timeout, count_out
    );

    modport slave (
        input  timer_in, bus_in, privileged,
        output timeout, count_out
    );
endinterface

// File: rtl/preempt_timer.sv
// Preemption quantum timer.
// A quantum is loaded from the bus with timer_in. The counter is decremented
// once every PRESCALE unprivileged clocks. When it reaches zero, the timer
// raises a sticky timeout that the control unit samples at instruction end.
// Optional feature macro: TIMER_AUTO_RELOAD_EN. When it is defined, each
// expiry reloads the counter from the stored quantum and counting continues.
module preempt_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 4     // legal range 1..256
) (
    input  logic           clk,
    input  logic           reset,  // asynchronous, active-low
    preempt_timer_if.slave bus
);
    localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } state_t;

    state_t           r_state,   w_state_nxt;
    logic [WIDTH-1:0] r_counter, w_counter_nxt;
    logic [PW-1:0]    r_presc,   w_presc_nxt;
    logic             r_timeout, w_timeout_nxt;
`ifdef TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_quantum, w_quantum_nxt;
`endif

    // State and datapath registers; all of them clear on reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its value from before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_presc   <= '0;
            r_timeout <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            r_quantum <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_presc   <= w_presc_nxt;
            r_timeout <= w_timeout_nxt;
`ifdef TIMER_AUTO_RELOAD_EN
            r_quantum <= w_quantum_nxt;
`endif
        end
    end

    // Next-state logic. A load has priority over any decrement or expiry that
    // would happen on the same clock.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_presc_nxt   = r_presc;
        w_timeout_nxt = r_timeout;
`ifdef TIMER_AUTO_RELOAD_EN
        w_quantum_nxt = r_quantum;
`endif

        if (bus.timer_in) begin
            w_counter_nxt = bus.bus_in;
            w_presc_nxt   = '0;
            w_timeout_nxt = 1'b0;
            w_state_nxt   = (bus.bus_in != '0) ? RUN : IDLE;
`ifdef TIMER_AUTO_RELOAD_EN
            w_quantum_nxt = bus.bus_in;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_timeout_nxt = 1'b0;
                end
                RUN: begin
                    // Kernel mode pauses the prescaler and the counter but
                    // keeps their progress.
                    if (!bus.privileged) begin
                        if (r_presc == PRESC_MAX) begin
                            w_presc_nxt = '0;
                            if (r_counter == WIDTH'(1)) begin
                                w_timeout_nxt = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                                w_counter_nxt = r_quantum;
`else
                                w_counter_nxt = '0;
                                w_state_nxt   = EXPIRED;
`endif
                            end else if (r_counter != '0) begin
                                w_counter_nxt = r_counter - WIDTH'(1);
                            end
                        end else begin
                            w_presc_nxt = r_presc + PW'(1);
                        end
                    end
                end
                EXPIRED: begin
                    // Only a fresh load leaves this state.
                    w_timeout_nxt = 1'b1;
                    w_counter_nxt = '0;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.timeout   = r_timeout;
    assign bus.count_out = r_counter;

endmodule

// File: tb/tb_preempt_timer.sv
// Self-checking bench for preempt_timer.
// The reference model counts unprivileged clocks since the last load and
// derives the expected counter and timeout arithmetically from that count.
module tb_preempt_timer;
    localparam int W = 16;
    localparam int P = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    preempt_timer_if #(.WIDTH(W)) bus_if ();

    preempt_timer #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    int   m_q;       // loaded quantum
    int   m_ticks;   // unprivileged clocks since load (or since last reload)
    bit   m_active;  // a quantum is currently counting
    int   m_hold;    // counter value while not counting
    bit   m_to;      // sticky timeout

    function automatic int exp_cnt();
        return m_active ? (m_q - m_ticks / P) : m_hold;
    endfunction

    task automatic model_reset();
        m_q = 0; m_ticks = 0; m_active = 0; m_hold = 0; m_to = 0;
    endtask

    task automatic model_edge(input bit ti, input int b, input bit pr);
        if (ti) begin
            m_q = b; m_ticks = 0; m_to = 0; m_active = (b != 0); m_hold = b;
        end else if (m_active && !pr) begin
            m_ticks++;
            if (m_ticks == m_q * P) begin
                m_to = 1;
`ifdef TIMER_AUTO_RELOAD_EN
                m_ticks = 0;
`else
                m_active = 0;
                m_hold   = 0;
`endif
            end
        end
    endtask

    // Apply one input vector for one clock and advance the model.
    task automatic step(input bit ti, input int b, input bit pr);
        @(negedge clk);
        bus_if.timer_in   = ti;
        bus_if.bus_in     = W'(b);
        bus_if.privileged = pr;
        @(posedge clk);
        model_edge(ti, b, pr);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (bus_if.timeout !== 1'b0 || bus_if.count_out !== W'(0)) begin
                miscompares++;
                $display("FAIL reset[%0d]: count_out=%0d timeout=%b, required 0/0",
                         i, bus_if.count_out, bus_if.timeout);
            end
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_load_count();
        step(1, 3, 0);
        for (int i = 1; i <= 32; i++) begin
            step(0, $urandom_range(0, 200), 0);
            vectors++;
            if (bus_if.count_out !== W'(exp_cnt()) || bus_if.timeout !== m_to) begin
                miscompares++;
                $display("FAIL load_count[%0d]: count_out=%0d timeout=%b, required %0d/%b",
                         i, bus_if.count_out, bus_if.timeout, exp_cnt(), m_to);
            end
            if (i == 4 || i == 8 || i == 12) begin
                int want_cnt;
                bit want_to;
`ifdef TIMER_AUTO_RELOAD_EN
                want_cnt = (i == 12) ? 3 : 3 - i / 4;
`else
                want_cnt = 3 - i / 4;
`endif
                want_to = (i == 12);
                vectors++;
                if (bus_if.count_out !== W'(want_cnt) || bus_if.timeout !== want_to) begin
                    miscompares++;
                    $display("FAIL load_latency[+%0d]: count_out=%0d timeout=%b, required %0d/%b",
                             i, bus_if.count_out, bus_if.timeout, want_cnt, want_to);
                end
            end
        end
    endtask

    task automatic test_priv_pause();
        step(1, 2, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1);
            vectors++;
            if (bus_if.count_out !== W'(1) || bus_if.timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL priv_pause[%0d]: count_out=%0d timeout=%b, required 1/0",
                         i, bus_if.count_out, bus_if.timeout);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0);
            vectors++;
            if (bus_if.timeout !== (i >= 3) || bus_if.count_out !== W'(exp_cnt())) begin
                miscompares++;
                $display("FAIL priv_resume[+%0d]: count_out=%0d timeout=%b, required %0d/%b",
                         i, bus_if.count_out, bus_if.timeout, exp_cnt(), (i >= 3));
            end
        end
    endtask

    task automatic test_zero_load();
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, $urandom_range(1, 100), $urandom_range(0, 1));
            vectors++;
            if (bus_if.timeout !== 1'b0 || bus_if.count_out !== W'(0)) begin
                miscompares++;
                $display("FAIL zero_load[%0d]: count_out=%0d timeout=%b, required 0/0",
                         i, bus_if.count_out, bus_if.timeout);
            end
        end
    endtask

    task automatic test_collision();
        step(1, 1, 0);
        for (int i = 0; i < P - 1; i++) step(0, 0, 0);
        step(1, 5, 0);
        vectors++;
        if (bus_if.timeout !== 1'b0 || bus_if.count_out !== W'(5)) begin
            miscompares++;
            $display("FAIL collision: count_out=%0d timeout=%b, required 5/0",
                     bus_if.count_out, bus_if.timeout);
        end
    endtask

    task automatic test_clear_expired();
        step(1, 1, 0);
        for (int i = 0; i < P; i++) step(0, 0, 0);
        vectors++;
        if (bus_if.timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL expire: timeout=%b, required 1", bus_if.timeout);
        end
        step(1, 2, 0);
        vectors++;
        if (bus_if.timeout !== 1'b0 || bus_if.count_out !== W'(2)) begin
            miscompares++;
            $display("FAIL clear_expired: count_out=%0d timeout=%b, required 2/0",
                     bus_if.count_out, bus_if.timeout);
        end
    endtask

    task automatic test_auto_reload();
        step(1, 2, 0);
        for (int i = 0; i < 6 * P; i++) begin
            step(0, 0, 0);
            vectors++;
            if (bus_if.count_out !== W'(exp_cnt()) || bus_if.timeout !== m_to) begin
                miscompares++;
                $display("FAIL auto_reload[%0d]: count_out=%0d timeout=%b, required %0d/%b",
                         i, bus_if.count_out, bus_if.timeout, exp_cnt(), m_to);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit ti;
            ti = ($urandom_range(0, 19) == 0);
            step(ti, $urandom_range(0, 6), ($urandom_range(0, 3) == 0));
            vectors++;
            if (bus_if.count_out !== W'(exp_cnt()) || bus_if.timeout !== m_to) begin
                miscompares++;
                $display("FAIL random[%0d]: count_out=%0d timeout=%b, required %0d/%b",
                         i, bus_if.count_out, bus_if.timeout, exp_cnt(), m_to);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1, 9, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (bus_if.timeout !== 1'b0 || bus_if.count_out !== W'(0)) begin
            miscompares++;
            $display("FAIL async_reset: count_out=%0d timeout=%b, required 0/0",
                     bus_if.count_out, bus_if.timeout);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0);
            vectors++;
            if (bus_if.timeout !== 1'b0 || bus_if.count_out !== W'(0)) begin
                miscompares++;
                $display("FAIL after_reset[%0d]: count_out=%0d timeout=%b, required 0/0",
                         i, bus_if.count_out, bus_if.timeout);
            end
        end
    endtask

    initial begin
        bus_if.timer_in   = 1'b0;
        bus_if.bus_in     = '0;
        bus_if.privileged = 1'b0;
        model_reset();
        test_reset();
        test_load_count();
        test_priv_pause();
        test_zero_load();
        test_collision();
        test_clear_expired();
        test_auto_reload();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
